// File: rtl/mem_tid_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_tid_arb_pkg
// Shared types and helpers for the memory TID arbiter.
//
// NR_REQ and TID_W live here rather than on the top module because the
// tid_t / src_t / cnt_t types every file uses are sized by them. Requester
// index 0 = icache refill, 1 = dcache load, 2 = dcache write-through store.
//
// Contents:
//   tid_t        transaction ID
//   src_t        requester index
//   cnt_t        count of TIDs (0 .. 2**TID_W)
//   fsm_state_e  IDLE / HOLD of the memory request port
//   free_res_t   result of lowest_free(): found flag + TID
//   lowest_free  lowest-numbered free TID of a busy vector
// -----------------------------------------------------------------------------
package mem_tid_arb_pkg;

    localparam int NR_REQ = 3;
    localparam int TID_W  = 2;
    localparam int POOL   = 1 << TID_W;
    localparam int SRC_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef logic [TID_W-1:0] tid_t;
    typedef logic [SRC_W-1:0] src_t;
    typedef logic [TID_W:0]   cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic found;
        tid_t tid;
    } free_res_t;

    // Scans from the top down so the last hit, i.e. the lowest index, wins.
    function automatic free_res_t lowest_free(input logic [POOL-1:0] busy);
        free_res_t res;
        res.found = 1'b0;
        res.tid   = '0;
        for (int i = POOL - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                res.found = 1'b1;
                res.tid   = tid_t'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_tid_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_lock
// NR_REQ-wide round-robin arbiter with a lock-while-pending hold.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester eligibility
//   lock         keep presenting the winner captured on the previous cycle
//   accept       the current grant is consumed; pointer moves past it
//   gnt_valid    a grant is presented
//   gnt_idx      index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter_lock
    import mem_tid_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NR_REQ-1:0] req,
    input  logic              lock,
    input  logic              accept,
    output logic              gnt_valid,
    output src_t              gnt_idx
);

    src_t ptr;
    src_t locked_idx;
    src_t pick;
    logic any;
    int   idx;

    // First eligible requester at or after the pointer, wrapping to 0.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = (int'(ptr) + k) % NR_REQ;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = src_t'(idx);
            end
        end
    end

    assign gnt_valid = lock | any;
    assign gnt_idx   = lock ? locked_idx : pick;

    // The live pick is captured every unlocked cycle so that it is ready the
    // moment the owner asserts lock after an unaccepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            locked_idx <= '0;
        end else begin
            if (!lock && any) begin
                locked_idx <= pick;
            end
            if (gnt_valid && accept) begin
                ptr <= (gnt_idx == src_t'(NR_REQ - 1)) ? '0 : gnt_idx + src_t'(1);
            end
        end
    end

endmodule

// File: rtl/mem_tid_arbiter.sv
// -----------------------------------------------------------------------------
// mem_tid_arbiter
// Shares the cache-to-memory request port between the icache refill, dcache
// load and dcache store requesters, allocates a TID per accepted request,
// routes responses back to the TID owner and caps in-flight stores.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/_store_i  per-requester request and store flag
//   req_ready_o        one-hot grant, handshake cycle only
//   req_tid_o          TID given to the granted requester
//   mem_valid_o/_ready_i  memory request handshake
//   mem_tid_o/_src_o   TID and requester index on the memory port
//   rsp_valid_i/_tid_i response from memory, never back-pressured
//   rsp_valid_o        one-hot response strobe to the TID owner
//   busy_cnt_o         number of allocated TIDs
//   err_o              sticky: response for an unallocated TID
//
// Optional (macro MEM_TID_ARB_PERF_EN):
//   stall_cnt_o        saturating count of cycles with a request but no
//                      eligible requester
//   store_stall_o      requester 2 blocked by the store limit alone
// -----------------------------------------------------------------------------
module mem_tid_arbiter
    import mem_tid_arb_pkg::*;
#(
    parameter int MAX_OUT_STORES = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_REQ-1:0] req_valid_i,
    input  logic [NR_REQ-1:0] req_store_i,
    output logic [NR_REQ-1:0] req_ready_o,
    output tid_t              req_tid_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output tid_t              mem_tid_o,
    output src_t              mem_src_o,
    input  logic              rsp_valid_i,
    input  tid_t              rsp_tid_i,
    output logic [NR_REQ-1:0] rsp_valid_o,
    output cnt_t              busy_cnt_o,
    output logic              err_o
`ifdef MEM_TID_ARB_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic              store_stall_o
`endif
);

    // Limits above the pool size can never be reached, so clamp them.
    localparam int STORE_LIMIT = (MAX_OUT_STORES > POOL) ? POOL : MAX_OUT_STORES;

    fsm_state_e        state;
    logic [POOL-1:0]   busy;
    logic [POOL-1:0]   store_tag;
    src_t              owner [POOL];
    tid_t              hold_tid;
    cnt_t              store_cnt;
    cnt_t              busy_cnt;
    free_res_t         free_tid;
    logic              store_ok;
    logic [NR_REQ-1:0] eligible;
    logic              gnt_valid;
    src_t              gnt_idx;
    logic              handshake;
    logic              rsp_hit;
    logic              hs_store;
    logic              rsp_store;

    // Allocation looks only at the registered busy vector, so a TID freed by
    // a response this cycle becomes available on the next one.
    assign free_tid = lowest_free(busy);
    assign store_ok = store_cnt < cnt_t'(STORE_LIMIT);
    assign eligible = free_tid.found ? (req_valid_i & (~req_store_i | {NR_REQ{store_ok}}))
                                     : '0;

    rr_arbiter_lock u_rr (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (eligible),
        .lock      (state == HOLD),
        .accept    (mem_ready_i),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign mem_valid_o = gnt_valid;
    assign mem_src_o   = gnt_idx;
    assign mem_tid_o   = (state == HOLD) ? hold_tid : free_tid.tid;
    assign handshake   = mem_valid_o & mem_ready_i;
    assign req_tid_o   = handshake ? mem_tid_o : '0;
    assign hs_store    = handshake & req_store_i[mem_src_o];

    assign rsp_hit     = rsp_valid_i & busy[rsp_tid_i];
    assign rsp_store   = rsp_hit & store_tag[rsp_tid_i];
    assign busy_cnt_o  = busy_cnt;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            req_ready_o[i] = handshake && (mem_src_o == src_t'(i));
            rsp_valid_o[i] = rsp_hit && (owner[rsp_tid_i] == src_t'(i));
        end
    end

    // Request-port FSM plus TID pool bookkeeping. A handshake and a response
    // in the same cycle always touch different TIDs: the handshake TID was
    // free at the start of the cycle, the response TID was busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            hold_tid  <= '0;
            busy      <= '0;
            store_tag <= '0;
            store_cnt <= '0;
            busy_cnt  <= '0;
            err_o     <= 1'b0;
            for (int i = 0; i < POOL; i++) begin
                owner[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid_o && !mem_ready_i) begin
                        state    <= HOLD;
                        hold_tid <= free_tid.tid;
                    end
                end
                HOLD: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rsp_hit) begin
                busy[rsp_tid_i] <= 1'b0;
            end
            if (handshake) begin
                busy[mem_tid_o]      <= 1'b1;
                owner[mem_tid_o]     <= mem_src_o;
                store_tag[mem_tid_o] <= hs_store;
            end
            if (rsp_valid_i && !rsp_hit) begin
                err_o <= 1'b1;
            end
            store_cnt <= store_cnt + cnt_t'(hs_store) - cnt_t'(rsp_store);
            busy_cnt  <= busy_cnt + cnt_t'(handshake) - cnt_t'(rsp_hit);
        end
    end

`ifdef MEM_TID_ARB_PERF_EN
    logic stall_now;
    logic store_block;

    assign stall_now   = (|req_valid_i) && !(|eligible);
    assign store_block = req_valid_i[NR_REQ-1] && req_store_i[NR_REQ-1]
                         && !store_ok && free_tid.found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o   <= '0;
            store_stall_o <= 1'b0;
        end else begin
            if (stall_now && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            store_stall_o <= store_block;
        end
    end
`endif

endmodule

// File: tb/tb_mem_tid_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_tid_arbiter
// Self-checking bench for mem_tid_arbiter built with MAX_OUT_STORES = 2.
// Expected grants (requester, TID) are queued as stimulus is driven and
// popped by a monitor whenever the DUT raises req_ready_o.
// -----------------------------------------------------------------------------
module tb_mem_tid_arbiter;
    import mem_tid_arb_pkg::*;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] tid;
    } grant_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req_valid = '0;
    logic [2:0] req_store = '0;
    logic [2:0] req_ready;
    tid_t       req_tid;
    logic       mem_valid;
    logic       mem_ready = 1'b0;
    tid_t       mem_tid;
    src_t       mem_src;
    logic       rsp_valid = 1'b0;
    tid_t       rsp_tid = '0;
    logic [2:0] rsp_valid_out;
    cnt_t       busy_cnt;
    logic       err;
`ifdef MEM_TID_ARB_PERF_EN
    logic [31:0] stall_cnt;
    logic        store_stall;
`endif

    grant_t grant_q[$];
    int     checks = 0;
    int     errors = 0;

    mem_tid_arbiter #(.MAX_OUT_STORES(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_store_i   (req_store),
        .req_ready_o   (req_ready),
        .req_tid_o     (req_tid),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mem_ready),
        .mem_tid_o     (mem_tid),
        .mem_src_o     (mem_src),
        .rsp_valid_i   (rsp_valid),
        .rsp_tid_i     (rsp_tid),
        .rsp_valid_o   (rsp_valid_out),
        .busy_cnt_o    (busy_cnt),
        .err_o         (err)
`ifdef MEM_TID_ARB_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .store_stall_o (store_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives a new input set just after the rising edge and returns at the
    // following falling edge, where outputs are sampled.
    task automatic applyStimulus(input logic [2:0] v, input logic [2:0] s,
                                 input logic rdy, input logic rv, input logic [1:0] rt);
        @(posedge clk);
        #1;
        req_valid = v;
        req_store = s;
        mem_ready = rdy;
        rsp_valid = rv;
        rsp_tid   = rt;
        @(negedge clk);
    endtask

    task automatic expectGrant(input logic [1:0] src, input logic [1:0] tid);
        grant_t g;
        g.src = src;
        g.tid = tid;
        grant_q.push_back(g);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        req_valid = '0;
        req_store = '0;
        mem_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Grant monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        grant_t g;
        if (rst_n && (req_ready != 3'b000)) begin
            if (grant_q.size() == 0) begin
                checkOutput("grant_unexpected", 32'(req_ready), 32'd0);
            end else begin
                g = grant_q.pop_front();
                checkOutput("grant_onehot", 32'(req_ready), 32'(3'b001 << g.src));
                checkOutput("grant_tid", 32'(req_tid), 32'(g.tid));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_mem_tid", 32'(mem_tid), 32'd0);
        checkOutput("rst_mem_src", 32'(mem_src), 32'd0);

        // Single load, zero latency
        expectGrant(2'd1, 2'd0);
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("load_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("load_mem_src", 32'(mem_src), 32'd1);
        checkOutput("load_mem_tid", 32'(mem_tid), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("load_busy_cnt", 32'(busy_cnt), 32'd1);
        checkOutput("load_idle_valid", 32'(mem_valid), 32'd0);
        checkOutput("load_sb_empty", 32'(grant_q.size()), 32'd0);

        // Round-robin and pool full
        doReset();
        expectGrant(2'd0, 2'd0);
        expectGrant(2'd1, 2'd1);
        expectGrant(2'd2, 2'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 2'd0);
            checkOutput("rr_mem_src", 32'(mem_src), 32'(i));
            checkOutput("rr_mem_tid", 32'(mem_tid), 32'(i));
        end
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("rr_busy_cnt", 32'(busy_cnt), 32'd3);
        expectGrant(2'd0, 2'd3);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 2'd0);
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("full_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("full_busy_cnt", 32'(busy_cnt), 32'd4);
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 2'd2);
        checkOutput("full_rsp_route", 32'(rsp_valid_out), 32'b100);
        checkOutput("full_no_reuse", 32'(mem_valid), 32'd0);
        expectGrant(2'd1, 2'd2);
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("full_reuse_tid", 32'(mem_tid), 32'd2);
        checkOutput("full_busy_after_rsp", 32'(busy_cnt), 32'd3);
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("full_busy_refill", 32'(busy_cnt), 32'd4);
        checkOutput("rr_sb_empty", 32'(grant_q.size()), 32'd0);

        // HOLD stability
        doReset();
        expectGrant(2'd1, 2'd0);
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 2'd0);
        checkOutput("hold_first_valid", 32'(mem_valid), 32'd1);
        checkOutput("hold_first_src", 32'(mem_src), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b011, 3'b000, 1'b0, 1'b0, 2'd0);
            checkOutput("hold_valid", 32'(mem_valid), 32'd1);
            checkOutput("hold_src", 32'(mem_src), 32'd1);
            checkOutput("hold_tid", 32'(mem_tid), 32'd0);
            checkOutput("hold_no_grant", 32'(req_ready), 32'd0);
        end
        applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("hold_accept_src", 32'(mem_src), 32'd1);
        expectGrant(2'd0, 2'd1);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("hold_wrap_src", 32'(mem_src), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("hold_busy_cnt", 32'(busy_cnt), 32'd2);
        checkOutput("hold_sb_empty", 32'(grant_q.size()), 32'd0);

        // Store limit (MAX_OUT_STORES = 2)
        doReset();
        expectGrant(2'd2, 2'd0);
        expectGrant(2'd2, 2'd1);
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        expectGrant(2'd1, 2'd2);
        applyStimulus(3'b110, 3'b100, 1'b1, 1'b0, 2'd0);
        checkOutput("st_load_src", 32'(mem_src), 32'd1);
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        checkOutput("st_blocked", 32'(mem_valid), 32'd0);
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b1, 2'd0);
        checkOutput("st_rsp_route", 32'(rsp_valid_out), 32'b100);
        checkOutput("st_still_blocked", 32'(mem_valid), 32'd0);
        expectGrant(2'd2, 2'd0);
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        checkOutput("st_release_valid", 32'(mem_valid), 32'd1);
        checkOutput("st_release_src", 32'(mem_src), 32'd2);
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        checkOutput("st_busy_cnt", 32'(busy_cnt), 32'd3);
        checkOutput("st_err", 32'(err), 32'd0);
        checkOutput("st_sb_empty", 32'(grant_q.size()), 32'd0);

        // Stray response on a free TID, then sticky error
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 2'd3);
        checkOutput("stray_rsp_valid", 32'(rsp_valid_out), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        checkOutput("stray_err", 32'(err), 32'd1);
        checkOutput("stray_busy_cnt", 32'(busy_cnt), 32'd3);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 2'd1);
        checkOutput("stray_good_rsp", 32'(rsp_valid_out), 32'b100);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        checkOutput("stray_err_sticky", 32'(err), 32'd1);
        checkOutput("stray_busy_after", 32'(busy_cnt), 32'd2);

        // Reset mid-transaction: stale response now flags an error
        doReset();
        checkOutput("rst2_err", 32'(err), 32'd0);
        checkOutput("rst2_busy_cnt", 32'(busy_cnt), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 2'd0);
        checkOutput("stale_rsp_valid", 32'(rsp_valid_out), 32'd0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        checkOutput("stale_err", 32'(err), 32'd1);

        checkOutput("final_sb_empty", 32'(grant_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_tid_arbiter.md
Name: mem_tid_arbiter

Overview:
- Shares the single cache-to-memory request port between NR_REQ requesters: icache refill, dcache load, dcache write-through store.
- On each accepted request, allocates a memory transaction ID (TID) from a pool of 2**TID_W.
- Routes each returning response back to the requester that owns its TID.
- Caps in-flight stores at MAX_OUT_STORES. Sits between the cache subsystem and the NoC adapter.

Parameters:
- NR_REQ, 3, number of requesters; index 0 = icache, 1 = dcache load, 2 = dcache store.
- TID_W, 2, TID width; pool size = 2**TID_W.
- MAX_OUT_STORES, 7, maximum stores in flight; valid range 1..2**TID_W (values above the pool size saturate at the pool size).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_REQ  per-requester request valid
- req_store_i  in  NR_REQ  per-requester "request is a store"
- req_ready_o  out  NR_REQ  one-hot grant; asserted in the handshake cycle only
- req_tid_o  out  TID_W  TID allocated to the granted requester; valid when any req_ready_o bit is set
- mem_valid_o  out  1  request valid toward memory
- mem_ready_i  in  1  memory accepts request
- mem_tid_o  out  TID_W  TID of the request on the memory port
- mem_src_o  out  clog2(NR_REQ)  requester index driving the memory port
- rsp_valid_i  in  1  response valid from memory; always accepted, no backpressure
- rsp_tid_i  in  TID_W  TID of the response
- rsp_valid_o  out  NR_REQ  one-hot response strobe to the owning requester
- busy_cnt_o  out  TID_W+1  number of TIDs currently allocated
- err_o  out  1  sticky: a response arrived for an unallocated TID

Behaviour:
- Reset values:
  - All TIDs free; all owner and store tags zero.
  - Store counter = 0; round-robin pointer = 0; FSM in IDLE.
  - All outputs 0.
- Eligibility:
  - A requester is eligible when req_valid_i=1 and (req_store_i=0 or store_cnt < MAX_OUT_STORES).
  - No requester is eligible when no TID is free.
- Arbitration:
  - Round-robin, starting at the pointer and wrapping at NR_REQ-1 back to 0.
  - The allocated TID is the lowest-numbered free TID.
- FSM:
  - IDLE: if any requester is eligible, drive mem_valid_o=1 combinationally with the winner's mem_src_o and mem_tid_o.
    - If mem_ready_i=1 in the same cycle: handshake, stay in IDLE.
    - Otherwise latch the winner index and TID, go to HOLD.
  - HOLD: mem_valid_o=1 with the latched src and tid; the selection does not change even if other requesters become eligible.
    - When mem_ready_i=1: handshake, go to IDLE.
  - The requester holding the grant in HOLD keeps req_valid_i high; the arbiter does not check this.
- Handshake (mem_valid_o & mem_ready_i):
  - req_ready_o[src]=1 and req_tid_o = mem_tid_o.
  - The TID is marked busy and its owner = src is recorded.
  - The TID's store tag = req_store_i[src]; store_cnt increments if it is a store.
  - The pointer becomes src+1, modulo NR_REQ.
- Latency: zero cycles from request to mem_valid_o when in IDLE with a TID available.
- Response path:
  - A response with rsp_valid_i=1 on a busy TID frees the TID in the same cycle.
  - rsp_valid_o[owner]=1, driven combinationally.
  - store_cnt decrements if the TID's store tag is set.
  - A response on a free TID: no state change, rsp_valid_o=0, err_o set to 1 until reset.
- Simultaneous handshake and response:
  - The TID freed this cycle is not reused until the next cycle; allocation uses free-state registered at the start of the cycle.
  - store_cnt nets +1 and -1 to no change.
  - busy_cnt_o is updated accordingly.
- Full pool: mem_valid_o=0 in IDLE; HOLD already owns its TID and is unaffected.
- Store limit:
  - At store_cnt == MAX_OUT_STORES, stores are ineligible and loads/ifetch still proceed.
- Asynchronous reset mid-transaction:
  - Clears all state immediately.
  - Responses for TIDs that were in flight before the reset then raise err_o.

Optional Feature:
- Macro MEM_TID_ARB_PERF_EN.
- When defined:
  - Adds output stall_cnt_o[31:0], which counts cycles with any req_valid_i=1 but no eligible requester (pool full or store limit), saturating at 2**32-1.
  - Adds output store_stall_o, which pulses on cycles where the store limit alone blocks requester 2.
  - Both reset to 0.
- When undefined: neither port nor the counter exists.

Decomposition:
- Shared package mem_tid_arb_pkg holds:
  - typedef tid_t (logic [TID_W-1:0]);
  - typedef src_t;
  - fsm_state_e {IDLE, HOLD};
  - function lowest_free(busy) returning the TID and a found flag.
- One natural sub-module, rr_arbiter_lock: NR_REQ-wide round-robin arbiter with pointer and lock-while-pending.

Test Plan:
- Single load: req_valid_i=3'b010 with mem_ready_i=1 -> same cycle mem_valid_o=1, mem_src_o=1, mem_tid_o=0, req_ready_o=3'b010; busy_cnt_o=1 the next cycle.
- Round-robin: req_valid_i=3'b111 held with mem_ready_i=1 for 3 cycles -> grants go to src 0, then 1, then 2, with TIDs 0, 1, 2.
- HOLD stability: requester 1 wins, then mem_ready_i=0 for 4 cycles while requester 0 also asserts -> mem_src_o stays 1 and mem_tid_o is unchanged until accept.
- Pool full: 4 requests accepted without responses -> mem_valid_o=0; then rsp_tid_i=2 -> rsp_valid_o goes to TID 2's owner, and the next cycle a new grant gets TID 2.
- Store limit with MAX_OUT_STORES=2: two stores outstanding, then both req 2 (store) and req 1 (load) valid -> req 1 granted and req 2 blocked; after one store response, req 2 is granted.
- Stray response: rsp_valid_i=1, rsp_tid_i=3 with TID 3 free -> rsp_valid_o=0 and err_o=1, which persists until rst_ni=0.
